pwm_motor_ctrl: RTL

//  Parametrised PWM motor/fan speed controller; successor to the fixed 4-level motor top.

---
 rtl/pwm_motor_ctrl_pkg.sv | 28 ++
 rtl/pwm_motor_ctrl_pwm_core.sv | 53 +++++
 rtl/pwm_motor_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pwm_motor_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pwm_motor_ctrl_pkg
//   Shared definitions for the PWM motor/fan speed controller:
//   - motor_state_t : 2-bit FSM encoding (IDLE / RAMP / RUN)
//   - calc_presc    : clock prescaler divide for a given carrier setup
//   - level_target  : duty target of a speed level, floor(L*PERIOD/(N-1))
// ----------------------------------------------------------------------------
package pwm_motor_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // level 0 and duty 0
        ST_RAMP = 2'd1,   // applied duty still moving toward the target
        ST_RUN  = 2'd2    // applied duty equals target, level > 0
    } motor_state_t;

    // Clocks per PWM counter step.
    function automatic int calc_presc(input int clk_hz, input int pwm_hz,
                                      input int period);
        return clk_hz / (pwm_hz * period);
    endfunction

    // Duty target of a level; the top level lands exactly on PERIOD.
    function automatic int level_target(input int lvl, input int period,
                                        input int n_levels);
        return (lvl * period) / (n_levels - 1);
    endfunction

endpackage

// File: rtl/pwm_motor_ctrl_pwm_core.sv
// ----------------------------------------------------------------------------
// pwm_core
//   Prescaler + PWM period counter + registered duty compare.
//   Ports:
//     i_clk    system clock
//     i_reset  synchronous reset, active-high
//     i_duty   duty in counter units (0..PERIOD)
//     o_pwm    registered PWM output, high while counter < duty
//     o_wrap   1-cycle strobe on the last step of a period (tick, cnt==PERIOD-1)
// ----------------------------------------------------------------------------
module pwm_core
    import pwm_motor_ctrl_pkg::*;
#(
    parameter int PRESC  = 100,
    parameter int PERIOD = 1000,
    parameter int CNT_W  = $clog2(PERIOD + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [CNT_W-1:0] i_duty,
    output logic             o_pwm,
    output logic             o_wrap
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PW-1:0]    r_presc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pwm;
    logic             w_tick;
    logic             w_last;

    // With PRESC==1 the prescaler stays at 0 and ticks every clock.
    assign w_tick = (r_presc == PW'(PRESC - 1));
    assign w_last = (r_cnt == CNT_W'(PERIOD - 1));
    assign o_wrap = w_tick && w_last;
    assign o_pwm  = r_pwm;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc <= '0;
            r_cnt   <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick)
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            // duty==PERIOD keeps this high for the whole period, 0 keeps it low
            r_pwm <= (r_cnt < i_duty);
        end
    end

endmodule

// File: rtl/pwm_motor_ctrl.sv
// ----------------------------------------------------------------------------
// pwm_motor_ctrl
//   PWM motor/fan speed controller with soft start / soft slow-down.
//   Button pulses (up/down/stop) move a speed level 0..N_LEVELS-1; the applied
//   duty ramps toward the level target by at most RAMP_STEP per PWM period,
//   changing only at period boundaries. Stop clears level and duty at once.
//   Ports:
//     i_clk      system clock
//     i_reset    synchronous reset, active-high
//     i_up       1-cycle pulse: level+1 (saturates at max)
//     i_down     1-cycle pulse: level-1 (saturates at 0)
//     i_stop     1-cycle pulse: emergency stop, highest priority
//     o_pwm      registered PWM drive
//     o_level    commanded level
//     o_duty     applied duty (0..PERIOD)
//     o_ramping  1 while applied duty differs from target
//     o_led      thermometer bar, bit k set iff o_level > k
// ----------------------------------------------------------------------------
module pwm_motor_ctrl
    import pwm_motor_ctrl_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int PWM_HZ    = 1_000,
    parameter int PERIOD    = 1000,
    parameter int N_LEVELS  = 5,
    parameter int RAMP_STEP = 50
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_up,
    input  logic                     i_down,
    input  logic                     i_stop,
    output logic                     o_pwm,
    output logic [$clog2(N_LEVELS)-1:0]      o_level,
    output logic [$clog2(PERIOD+1)-1:0]      o_duty,
    output logic                     o_ramping,
    output logic [N_LEVELS-2:0]      o_led
);

    localparam int CNT_W  = $clog2(PERIOD + 1);
    localparam int LVL_W  = $clog2(N_LEVELS);
    localparam int PRESC  = calc_presc(CLK_HZ, PWM_HZ, PERIOD);
    // A step larger than the full range behaves like a full-range jump.
    localparam int STEP_C = (RAMP_STEP > PERIOD) ? PERIOD : RAMP_STEP;

    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(N_LEVELS - 1);
    localparam logic [CNT_W-1:0] STEP    = CNT_W'(STEP_C);

    generate
        if (PRESC < 1) begin : g_bad_presc
            $error("pwm_motor_ctrl: CLK_HZ/(PWM_HZ*PERIOD) must be >= 1");
        end
        if (N_LEVELS < 2) begin : g_bad_levels
            $error("pwm_motor_ctrl: N_LEVELS must be >= 2");
        end
        if (RAMP_STEP < 1) begin : g_bad_step
            $error("pwm_motor_ctrl: RAMP_STEP must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Level -> duty target lookup (constant table folded at elaboration)
    // ------------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] tgt_of(input logic [LVL_W-1:0] lvl);
        logic [CNT_W-1:0] t;
        t = '0;
        for (int k = 0; k < N_LEVELS; k++)
            if (lvl == LVL_W'(k))
                t = CNT_W'(level_target(k, PERIOD, N_LEVELS));
        return t;
    endfunction

    function automatic logic [N_LEVELS-2:0] thermo(input logic [LVL_W-1:0] lvl);
        logic [N_LEVELS-2:0] t;
        t = '0;
        for (int k = 0; k < N_LEVELS - 1; k++)
            t[k] = (lvl > LVL_W'(k));
        return t;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [LVL_W-1:0]    r_level;
    logic [CNT_W-1:0]    r_duty;
    logic [N_LEVELS-2:0] r_led;
    motor_state_t        r_state;

    logic [LVL_W-1:0]    w_level_nxt;
    logic [CNT_W-1:0]    w_duty_nxt;
    logic [CNT_W-1:0]    w_tgt;
    logic [CNT_W-1:0]    w_tgt_nxt;
    motor_state_t        w_state_nxt;
    logic                w_wrap;

    pwm_core #(
        .PRESC  (PRESC),
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_pwm_core (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_duty  (r_duty),
        .o_pwm   (o_pwm),
        .o_wrap  (w_wrap)
    );

    assign w_tgt     = tgt_of(r_level);
    assign w_tgt_nxt = tgt_of(w_level_nxt);

    // Level: stop > (up & down ignored) > up > down, no tick required.
    always_comb begin
        w_level_nxt = r_level;
        if (i_stop) begin
            w_level_nxt = '0;
        end else if (i_up && i_down) begin
            w_level_nxt = r_level;
        end else if (i_up) begin
            if (r_level != LVL_MAX)
                w_level_nxt = r_level + LVL_W'(1);
        end else if (i_down) begin
            if (r_level != '0)
                w_level_nxt = r_level - LVL_W'(1);
        end
    end

    // Duty only moves at a period wrap so every period is glitch-free; the
    // final step is clamped to the target so it never overshoots.
    always_comb begin
        w_duty_nxt = r_duty;
        if (i_stop) begin
            w_duty_nxt = '0;
        end else if (w_wrap) begin
            if (w_tgt > r_duty)
                w_duty_nxt = ((w_tgt - r_duty) > STEP) ? r_duty + STEP : w_tgt;
            else if (w_tgt < r_duty)
                w_duty_nxt = ((r_duty - w_tgt) > STEP) ? r_duty - STEP : w_tgt;
        end
    end

    // Next state follows from next level/duty, so a level change that moves
    // the target enters RAMP on the same edge, and reaching the target (or
    // zero at level 0) leaves it on the edge that lands there.
    always_comb begin
        if (i_stop)
            w_state_nxt = ST_IDLE;
        else if (w_duty_nxt != w_tgt_nxt)
            w_state_nxt = ST_RAMP;
        else if (w_level_nxt == '0)
            w_state_nxt = ST_IDLE;
        else
            w_state_nxt = ST_RUN;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_level <= '0;
            r_duty  <= '0;
            r_led   <= '0;
            r_state <= ST_IDLE;
        end else begin
            r_level <= w_level_nxt;
            r_duty  <= w_duty_nxt;
            r_led   <= thermo(w_level_nxt);
            r_state <= w_state_nxt;
        end
    end

    assign o_level   = r_level;
    assign o_duty    = r_duty;
    assign o_led     = r_led;
    assign o_ramping = (r_state == ST_RAMP);

endmodule
